// File: rtl/vram_pkg.sv
// Shared widths, text-page geometry, clear fill word and the enums for the VRAM port arbiter.
package vram_pkg;
    localparam int AW        = 11;
    localparam int DW        = 16;
    localparam int TEXT_COLS = 40;
    localparam int TEXT_ROWS = 28;

    localparam logic [AW-1:0] CLR_LAST_DEF = AW'(TEXT_COLS * TEXT_ROWS - 1);
    localparam logic [DW-1:0] CLR_WORD_DEF = 16'h0F00;

    // Which source issued the RAM access currently in the read-return pipeline.
    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_R0,
        OWN_R1,
        OWN_CLR
    } owner_t;

    typedef enum logic [1:0] {
        CLR_IDLE,
        CLR_FILL,
        CLR_DONE
    } clr_state_t;
endpackage

// File: rtl/vram_port_arbiter_if.sv
// Requester and RAM-side bundle of the VRAM port arbiter; slave = arbiter, master = requesters/RAM.
interface vram_port_arbiter_if;
    import vram_pkg::*;

    // rN_req is raised with we/addr/wdata stable and held until rN_ack pulses for one cycle;
    // reads later return exactly one rN_rvalid pulse with rN_rdata, writes return nothing.
    logic          r0_req;
    logic          r0_we;
    logic [AW-1:0] r0_addr;
    logic [DW-1:0] r0_wdata;
    logic          r0_ack;
    logic          r0_rvalid;
    logic [DW-1:0] r0_rdata;

    logic          r1_req;
    logic          r1_we;
    logic [AW-1:0] r1_addr;
    logic [DW-1:0] r1_wdata;
    logic          r1_ack;
    logic          r1_rvalid;
    logic [DW-1:0] r1_rdata;

    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  r0_req, r0_we, r0_addr, r0_wdata,
        output r0_ack, r0_rvalid, r0_rdata,
        input  r1_req, r1_we, r1_addr, r1_wdata,
        output r1_ack, r1_rvalid, r1_rdata,
        output mem_addr, mem_data, mem_we,
        input  mem_rdata
    );

    modport master (
        output r0_req, r0_we, r0_addr, r0_wdata,
        input  r0_ack, r0_rvalid, r0_rdata,
        output r1_req, r1_we, r1_addr, r1_wdata,
        input  r1_ack, r1_rvalid, r1_rdata,
        input  mem_addr, mem_data, mem_we,
        output mem_rdata
    );
endinterface

// File: rtl/vram_clear_seq.sv
// Page-clear sequencer: IDLE -> FILL (one address per cycle, 0..CLR_LAST) -> DONE -> IDLE.
module vram_clear_seq
    import vram_pkg::*;
#(
    parameter logic [AW-1:0] CLR_LAST = CLR_LAST_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          claim,
    output logic [AW-1:0] addr,
    output clr_state_t    state
);
    clr_state_t    state_nxt;
    logic [AW-1:0] cnt;
    logic [AW-1:0] cnt_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= CLR_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            CLR_IDLE: begin
                if (start) begin
                    state_nxt = CLR_FILL;
                    cnt_nxt   = '0;
                end
            end
            CLR_FILL: begin
                if (cnt == CLR_LAST) state_nxt = CLR_DONE;
                else                 cnt_nxt   = cnt + AW'(1);
            end
            CLR_DONE: state_nxt = CLR_IDLE;
            default:  state_nxt = CLR_IDLE;
        endcase
    end

    assign busy  = (state == CLR_FILL);
    assign done  = (state == CLR_DONE);
    // The start edge already blocks the requesters so the first fill write is not delayed.
    assign claim = busy || ((state == CLR_IDLE) && start);
    assign addr  = cnt;
endmodule

// File: rtl/vram_port_arbiter.sv
// Round-robin arbiter sharing the text VRAM between r0/r1 with registered RAM drive and read return.
// Define VRAM_CLEAR_EN to include the page-clear sequencer; otherwise clr_busy/clr_done stay 0.
module vram_port_arbiter
    import vram_pkg::*;
#(
    parameter logic [AW-1:0] CLR_LAST = CLR_LAST_DEF,
    parameter logic [DW-1:0] CLR_WORD = CLR_WORD_DEF
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic                 clr_start,
    output logic                 clr_busy,
    output logic                 clr_done,
    output clr_state_t           clr_state,
    vram_port_arbiter_if.slave   bus
);
    logic          clr_claim;
    logic          clr_fill;
    logic [AW-1:0] clr_addr;

`ifdef VRAM_CLEAR_EN
    vram_clear_seq #(
        .CLR_LAST (CLR_LAST)
    ) u_clear (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .start (clr_start),
        .busy  (clr_busy),
        .done  (clr_done),
        .claim (clr_claim),
        .addr  (clr_addr),
        .state (clr_state)
    );
    assign clr_fill = clr_busy;
`else
    logic          unused_clr_start;
    logic [AW-1:0] unused_clr_last;
    assign unused_clr_start = clr_start;
    assign unused_clr_last  = CLR_LAST;
    assign clr_busy  = 1'b0;
    assign clr_done  = 1'b0;
    assign clr_claim = 1'b0;
    assign clr_fill  = 1'b0;
    assign clr_addr  = '0;
    assign clr_state = CLR_IDLE;
`endif

    logic   last_grant;  // 1 = r1 was granted most recently
    logic   elig0, elig1;
    logic   grant0, grant1;
    owner_t tag1, tag2;

    // A requester is not eligible in its own ack cycle, so a held request is not granted twice.
    assign elig0  = bus.r0_req && !bus.r0_ack;
    assign elig1  = bus.r1_req && !bus.r1_ack;
    assign grant0 = !clr_claim && elig0 && (!elig1 || last_grant);
    assign grant1 = !clr_claim && elig1 && (!elig0 || !last_grant);

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            bus.r0_ack    <= 1'b0;
            bus.r1_ack    <= 1'b0;
            bus.r0_rvalid <= 1'b0;
            bus.r1_rvalid <= 1'b0;
            bus.r0_rdata  <= '0;
            bus.r1_rdata  <= '0;
            bus.mem_addr  <= '0;
            bus.mem_data  <= '0;
            bus.mem_we    <= 1'b0;
            last_grant    <= 1'b1;
            tag1          <= OWN_NONE;
            tag2          <= OWN_NONE;
        end else begin
            bus.r0_ack <= grant0;
            bus.r1_ack <= grant1;
            tag2       <= tag1;

            if (clr_fill) begin
                bus.mem_addr <= clr_addr;
                bus.mem_data <= CLR_WORD;
                bus.mem_we   <= 1'b1;
                tag1         <= OWN_CLR;
            end else if (grant0) begin
                bus.mem_addr <= bus.r0_addr;
                bus.mem_data <= bus.r0_wdata;
                bus.mem_we   <= bus.r0_we;
                tag1         <= bus.r0_we ? OWN_NONE : OWN_R0;
                last_grant   <= 1'b0;
            end else if (grant1) begin
                bus.mem_addr <= bus.r1_addr;
                bus.mem_data <= bus.r1_wdata;
                bus.mem_we   <= bus.r1_we;
                tag1         <= bus.r1_we ? OWN_NONE : OWN_R1;
                last_grant   <= 1'b1;
            end else begin
                bus.mem_we <= 1'b0;
                tag1       <= OWN_NONE;
            end

            // tag2 lines up with the cycle in which the RAM presents the word for that access.
            bus.r0_rvalid <= (tag2 == OWN_R0);
            bus.r1_rvalid <= (tag2 == OWN_R1);
            if (tag2 == OWN_R0) bus.r0_rdata <= bus.mem_rdata;
            if (tag2 == OWN_R1) bus.r1_rdata <= bus.mem_rdata;
        end
    end
endmodule

// File: tb/tb_vram_port_arbiter.sv
// Directed bench for vram_port_arbiter with a synchronous-read RAM model on the mem_* side.
module tb_vram_port_arbiter;
  import vram_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr_start = 1'b0;
  logic       clr_busy;
  logic       clr_done;
  clr_state_t clr_state;
  int         checks = 0;
  int         failures = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] ram [0:(1<<AW)-1];

  vram_port_arbiter_if bus();

  vram_port_arbiter dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .clr_start (clr_start),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done),
    .clr_state (clr_state),
    .bus       (bus)
  );

  // clock / reset block
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_data;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.r0_req = 1'b0; bus.r0_we = 1'b0; bus.r0_addr = '0; bus.r0_wdata = '0;
    bus.r1_req = 1'b0; bus.r1_we = 1'b0; bus.r1_addr = '0; bus.r1_wdata = '0;
    clr_start = 1'b0;
  endtask

  task automatic reset_dut();
    drive_idle();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_dut();
    checks++;
    if ({bus.r0_ack, bus.r1_ack, bus.r0_rvalid, bus.r1_rvalid, bus.mem_we, clr_busy, clr_done} !== 7'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=0000000",
               {bus.r0_ack, bus.r1_ack, bus.r0_rvalid, bus.r1_rvalid, bus.mem_we, clr_busy, clr_done});
    end
    checks++;
    if ({bus.mem_addr, bus.mem_data, bus.r0_rdata, bus.r1_rdata} !== '0) begin
      failures++;
      $display("FAIL reset_buses addr=%h data=%h rd0=%h rd1=%h exp=0",
               bus.mem_addr, bus.mem_data, bus.r0_rdata, bus.r1_rdata);
    end
  endtask

  task automatic test_read();
    reset_dut();
    bus.r0_req = 1'b1; bus.r0_we = 1'b0; bus.r0_addr = 11'h028;
    tick();
    checks++;
    if ({bus.r0_ack, bus.r1_ack, bus.mem_we, bus.mem_addr} !== {3'b100, 11'h028}) begin
      failures++;
      $display("FAIL read_issue ack0=%b ack1=%b we=%b addr=%h exp=1 0 0 028",
               bus.r0_ack, bus.r1_ack, bus.mem_we, bus.mem_addr);
    end
    bus.r0_req = 1'b0;
    tick();
    checks++;
    if ({bus.r0_ack, bus.r0_rvalid} !== 2'b00) begin
      failures++;
      $display("FAIL read_e1 ack0=%b rvalid0=%b exp=0 0", bus.r0_ack, bus.r0_rvalid);
    end
    tick();
    checks++;
    if ({bus.r0_rvalid, bus.r0_rdata, bus.r1_rvalid} !== {1'b1, 16'h0F41, 1'b0}) begin
      failures++;
      $display("FAIL read_return rvalid0=%b rdata0=%h rvalid1=%b exp=1 0f41 0",
               bus.r0_rvalid, bus.r0_rdata, bus.r1_rvalid);
    end
    tick();
    checks++;
    if (bus.r0_rvalid !== 1'b0 || bus.r0_rdata !== 16'h0F41) begin
      failures++;
      $display("FAIL read_hold rvalid0=%b rdata0=%h exp=0 0f41", bus.r0_rvalid, bus.r0_rdata);
    end
  endtask

  task automatic test_round_robin();
    logic exp0;
    reset_dut();
    bus.r0_req = 1'b1; bus.r0_addr = 11'h100;
    bus.r1_req = 1'b1; bus.r1_addr = 11'h200;
    for (int i = 0; i < 4; i++) begin
      tick();
      exp0 = (i % 2 == 0);
      checks++;
      if ({bus.r0_ack, bus.r1_ack} !== {exp0, !exp0}) begin
        failures++;
        $display("FAIL rr_ack%0d got=%b%b exp=%b%b", i, bus.r0_ack, bus.r1_ack, exp0, !exp0);
      end
      checks++;
      if (bus.mem_addr !== (exp0 ? 11'h100 : 11'h200)) begin
        failures++;
        $display("FAIL rr_addr%0d got=%h exp=%h", i, bus.mem_addr, exp0 ? 11'h100 : 11'h200);
      end
    end
    drive_idle();
    repeat (3) tick();
  endtask

  task automatic test_write();
    reset_dut();
    bus.r0_req = 1'b1; bus.r0_we = 1'b1; bus.r0_addr = 11'h45F; bus.r0_wdata = 16'h4F20;
    tick();
    checks++;
    if ({bus.r0_ack, bus.mem_we, bus.mem_addr, bus.mem_data} !== {2'b11, 11'h45F, 16'h4F20}) begin
      failures++;
      $display("FAIL write_issue ack0=%b we=%b addr=%h data=%h exp=1 1 45f 4f20",
               bus.r0_ack, bus.mem_we, bus.mem_addr, bus.mem_data);
    end
    drive_idle();
    tick();
    checks++;
    if (bus.mem_we !== 1'b0 || bus.mem_addr !== 11'h45F) begin
      failures++;
      $display("FAIL write_idle we=%b addr=%h exp=0 45f", bus.mem_we, bus.mem_addr);
    end
    tick();
    checks++;
    if ({bus.r0_rvalid, bus.r1_rvalid} !== 2'b00 || ram[11'h45F] !== 16'h4F20) begin
      failures++;
      $display("FAIL write_norvalid rvalid=%b%b ram=%h exp=00 4f20",
               bus.r0_rvalid, bus.r1_rvalid, ram[11'h45F]);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp_w;
    reset_dut();
    exp_q.push_back(16'h2F31);
    exp_q.push_back(16'h1E32);
    bus.r0_req = 1'b1; bus.r0_addr = 11'h001;
    bus.r1_req = 1'b1; bus.r1_addr = 11'h002;
    tick();
    bus.r0_req = 1'b0;
    tick();
    checks++;
    if ({bus.r0_ack, bus.r1_ack} !== 2'b01) begin
      failures++;
      $display("FAIL b2b_ack1 got=%b%b exp=01", bus.r0_ack, bus.r1_ack);
    end
    bus.r1_req = 1'b0;
    tick();
    exp_w = exp_q.pop_front();
    checks++;
    if ({bus.r0_rvalid, bus.r1_rvalid, bus.r0_rdata} !== {2'b10, exp_w}) begin
      failures++;
      $display("FAIL b2b_r0 rvalid=%b%b rdata0=%h exp=10 %h", bus.r0_rvalid, bus.r1_rvalid, bus.r0_rdata, exp_w);
    end
    tick();
    exp_w = exp_q.pop_front();
    checks++;
    if ({bus.r0_rvalid, bus.r1_rvalid, bus.r1_rdata} !== {2'b01, exp_w}) begin
      failures++;
      $display("FAIL b2b_r1 rvalid=%b%b rdata1=%h exp=01 %h", bus.r0_rvalid, bus.r1_rvalid, bus.r1_rdata, exp_w);
    end
  endtask

`ifdef VRAM_CLEAR_EN
  task automatic test_clear();
    int bad = 0;
    int done_cnt = 0;
    reset_dut();
    bus.r1_req = 1'b1; bus.r1_we = 1'b0; bus.r1_addr = 11'h010;
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    checks++;
    if ({clr_busy, bus.r1_ack, bus.mem_we} !== 3'b100) begin
      failures++;
      $display("FAIL clr_start busy=%b ack1=%b we=%b exp=1 0 0", clr_busy, bus.r1_ack, bus.mem_we);
    end
    for (int k = 0; k < 1120; k++) begin
      tick();
      if (bus.mem_we !== 1'b1 || bus.mem_addr !== AW'(k) || bus.mem_data !== 16'h0F00 ||
          bus.r1_ack !== 1'b0 || (k < 1119 && clr_busy !== 1'b1)) bad++;
      if (clr_done === 1'b1) done_cnt++;
      if (k == 5) clr_start = 1'b1;
      if (k == 6) clr_start = 1'b0;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL clr_fill bad_cycles=%0d exp=0", bad);
    end
    checks++;
    if ({clr_done, clr_busy} !== 2'b10) begin
      failures++;
      $display("FAIL clr_done_pulse done=%b busy=%b exp=1 0", clr_done, clr_busy);
    end
    tick();
    if (clr_done === 1'b1) done_cnt++;
    checks++;
    if ({bus.r1_ack, bus.mem_we, bus.mem_addr} !== {2'b10, 11'h010}) begin
      failures++;
      $display("FAIL clr_resume ack1=%b we=%b addr=%h exp=1 0 010", bus.r1_ack, bus.mem_we, bus.mem_addr);
    end
    bus.r1_req = 1'b0;
    tick();
    if (clr_done === 1'b1) done_cnt++;
    tick();
    if (clr_done === 1'b1) done_cnt++;
    checks++;
    if ({bus.r1_rvalid, bus.r1_rdata} !== {1'b1, 16'h0F00}) begin
      failures++;
      $display("FAIL clr_readback rvalid1=%b rdata1=%h exp=1 0f00", bus.r1_rvalid, bus.r1_rdata);
    end
    checks++;
    if (done_cnt != 1 || clr_busy !== 1'b0) begin
      failures++;
      $display("FAIL clr_done_count got=%0d busy=%b exp=1 0", done_cnt, clr_busy);
    end
    checks++;
    if (ram[0] !== 16'h0F00 || ram[1119] !== 16'h0F00 || ram[1120] !== 16'hBEEF) begin
      failures++;
      $display("FAIL clr_ram_edges r0=%h r1119=%h r1120=%h exp=0f00 0f00 beef", ram[0], ram[1119], ram[1120]);
    end
  endtask
`else
  task automatic test_clear_disabled();
    int seen = 0;
    reset_dut();
    bus.r1_req = 1'b1; bus.r1_we = 1'b0; bus.r1_addr = 11'h010;
    clr_start = 1'b1;
    tick();
    checks++;
    if ({bus.r1_ack, clr_busy, clr_done, bus.mem_addr} !== {3'b100, 11'h010}) begin
      failures++;
      $display("FAIL noclr_grant ack1=%b busy=%b done=%b addr=%h exp=1 0 0 010",
               bus.r1_ack, clr_busy, clr_done, bus.mem_addr);
    end
    drive_idle();
    for (int k = 0; k < 4; k++) begin
      tick();
      if (clr_busy !== 1'b0 || clr_done !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0 || bus.r1_rdata !== 16'h0A10) begin
      failures++;
      $display("FAIL noclr_quiet flag_cycles=%0d rdata1=%h exp=0 0a10", seen, bus.r1_rdata);
    end
  endtask
`endif

  task automatic test_reset_midflight();
    int seen = 0;
    reset_dut();
    bus.r0_req = 1'b1; bus.r0_we = 1'b0; bus.r0_addr = 11'h028;
    tick();
    bus.r0_req = 1'b0;
    rst_n = 1'b0;
    tick();
    checks++;
    if ({bus.r0_ack, bus.mem_we, bus.mem_addr, bus.mem_data} !== '0) begin
      failures++;
      $display("FAIL rst_read ack0=%b we=%b addr=%h data=%h exp=0",
               bus.r0_ack, bus.mem_we, bus.mem_addr, bus.mem_data);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (bus.r0_rvalid !== 1'b0 || bus.r0_rdata !== '0) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL rst_read_drop rvalid_cycles=%0d exp=0", seen);
    end
`ifdef VRAM_CLEAR_EN
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    repeat (10) tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if ({clr_busy, clr_done, bus.mem_we, bus.mem_addr} !== '0) begin
      failures++;
      $display("FAIL rst_fill busy=%b done=%b we=%b addr=%h exp=0",
               clr_busy, clr_done, bus.mem_we, bus.mem_addr);
    end
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (clr_done !== 1'b0 || clr_busy !== 1'b0 || bus.mem_we !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL rst_fill_quiet active_cycles=%0d exp=0", seen);
    end
`endif
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) ram[i] = 16'h3000 | DW'(i);
    ram[11'h028] = 16'h0F41;
    ram[11'h001] = 16'h2F31;
    ram[11'h002] = 16'h1E32;
    ram[11'h010] = 16'h0A10;
    ram[1120]    = 16'hBEEF;
    bus.mem_rdata = '0;
    drive_idle();

    test_reset();
    test_read();
    test_round_robin();
    test_write();
    test_back_to_back();
`ifdef VRAM_CLEAR_EN
    test_clear();
`else
    test_clear_disabled();
`endif
    test_reset_midflight();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
